// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator: one DDS phase accumulator per
// channel, gated by a synchronised PLL lock with a settle hold-off.
module clk_en_gen #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 24,
  parameter int HOLDOFF  = 1024,
  parameter logic [CHANNELS*ACC_W-1:0] INC_INIT = '0,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                LOCKED,
  input  logic                INC_WE,
  input  logic [SEL_W-1:0]    INC_SEL,
  input  logic [ACC_W-1:0]    INC_DATA,
  output logic [CHANNELS-1:0] EN,
  output logic [CHANNELS-1:0] TOG,
  output logic                READY
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_e;

  logic                lock_meta_q, lock_s_q;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                acc_en;
  logic [ACC_W-1:0]    acc_q  [CHANNELS];
  logic [ACC_W-1:0]    acc_d  [CHANNELS];
  logic [ACC_W-1:0]    inc_q  [CHANNELS];
  logic [ACC_W-1:0]    inc_d  [CHANNELS];
  logic [ACC_W-1:0]    pend_q [CHANNELS];
  logic [ACC_W-1:0]    pend_d [CHANNELS];
  logic [ACC_W:0]      sum    [CHANNELS];
  logic [CHANNELS-1:0] pflag_q, pflag_d, en_q, en_d, tog_q, tog_d, carry, apply;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update together on the edge regardless of process evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= LOCKED;
      lock_s_q    <= lock_meta_q;
    end
  end

  // NOTE: each always_comb assigns defaults first so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s_q) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s_q) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready_d = (state_d == RUN);
  // Accumulate only on edges that start and end in RUN; entry and exit edges clear.
  assign acc_en  = (state_q == RUN) && (state_d == RUN);

  always_comb begin
    pflag_d = pflag_q;
    en_d    = '0;
    tog_d   = '0;
    carry   = '0;
    apply   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i]    = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      carry[i]  = sum[i][ACC_W];
      // A pending increment swaps in only at a wrap, when idle, or outside RUN.
      apply[i]  = pflag_q[i] && (carry[i] || (inc_q[i] == '0) || (state_q != RUN));
      inc_d[i]  = apply[i] ? pend_q[i] : inc_q[i];
      pend_d[i] = pend_q[i];
      if (apply[i]) pflag_d[i] = 1'b0;
      if (INC_WE && (INC_SEL == SEL_W'(i))) begin
        pend_d[i]  = INC_DATA;
        pflag_d[i] = 1'b1;
      end
      if (acc_en) begin
        acc_d[i] = sum[i][ACC_W-1:0];
        en_d[i]  = carry[i];
        tog_d[i] = tog_q[i] ^ carry[i];
      end else begin
        acc_d[i] = '0;
      end
    end
  end

  // NOTE: the increment and pending arrays are reset deliberately; the
  // increments must come up holding INC_INIT, so they are state, not storage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      en_q    <= '0;
      tog_q   <= '0;
      pflag_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]  <= '0;
        inc_q[i]  <= INC_INIT[i*ACC_W +: ACC_W];
        pend_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      tog_q   <= tog_d;
      pflag_q <= pflag_d;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]  <= acc_d[i];
        inc_q[i]  <= inc_d[i];
        pend_q[i] <= pend_d[i];
      end
    end
  end

  assign EN    = en_q;
  assign TOG   = tog_q;
  assign READY = ready_q;

endmodule
